// File: rtl/axil_master_pkg.sv
// rtl/axil_master_pkg.sv - shared FSM encoding, response codes and accelerator register map
package axil_master_pkg;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WR_ADDR_DATA = 3'd1,
    WR_RESP      = 3'd2,
    RD_ADDR      = 3'd3,
    RD_DATA      = 3'd4,
    RESP         = 3'd5
  } state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Matrix-multiply accelerator register offsets
  localparam logic [7:0] REG_CTRL   = 8'h00;
  localparam logic [7:0] REG_STATUS = 8'h04;
  localparam logic [7:0] REG_DIM_M  = 8'h08;
  localparam logic [7:0] REG_DIM_K  = 8'h0C;
  localparam logic [7:0] REG_DIM_N  = 8'h10;
  localparam logic [7:0] REG_ADDR   = 8'h14;
  localparam logic [7:0] REG_WDATA  = 8'h18;
  localparam logic [7:0] REG_RDATA  = 8'h1C;

endpackage

// File: rtl/axil_master_if.sv
// rtl/axil_master_if.sv - AXI4-Lite bus bundle with master and slave views
interface axil_master_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wvalid, input wready,
    input bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input rdata, rresp, rvalid, output rready
  );

  modport slave (
    input awaddr, awprot, awvalid, output awready,
    input wdata, wstrb, wvalid, output wready,
    output bresp, bvalid, input bready,
    input araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/axil_master_watchdog.sv
// rtl/axil_master_watchdog.sv - stall counter that expires after LIMIT cycles without a handshake
module axil_master_watchdog #(
  parameter int LIMIT = 1024
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  input  logic clear_i,
  output logic expire_o
);
  localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  // A handshake in the final cycle counts as progress and wins over expiry
  assign expire_o = run_i && !clear_i && (cnt_q == CW'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (!run_i || clear_i) begin
      cnt_d = '0;
    end else if (!expire_o) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/axil_master_engine.sv
// rtl/axil_master_engine.sv - single-outstanding AXI4-Lite initiator; AXIL_MASTER_TIMEOUT_EN adds a watchdog
module axil_master_engine
  import axil_master_pkg::*;
#(
  parameter int C_M00_AXI_ADDR_WIDTH = 8,
  parameter int C_M00_AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES       = 1024
) (
  input  logic                                m00_axi_aclk,
  input  logic                                m00_axi_areset,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic                                cmd_write,
  input  logic [C_M00_AXI_ADDR_WIDTH-1:0]     cmd_addr,
  input  logic [C_M00_AXI_DATA_WIDTH-1:0]     cmd_wdata,
  input  logic [C_M00_AXI_DATA_WIDTH/8-1:0]   cmd_wstrb,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [C_M00_AXI_DATA_WIDTH-1:0]     rsp_rdata,
  output logic [1:0]                          rsp_resp,
  output logic                                rsp_timeout,
  axil_master_if.master                       m00_axi
);
  localparam int AW = C_M00_AXI_ADDR_WIDTH;
  localparam int DW = C_M00_AXI_DATA_WIDTH;
  localparam int SW = DW / 8;

  state_e          state_q, state_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic            arvalid_q, arvalid_d, rready_q, rready_d;
  logic            rsp_valid_q, rsp_valid_d, timeout_q, timeout_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d, rdata_q, rdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;
  logic [1:0]      resp_q, resp_d;
  logic            aw_hs, w_hs, b_hs, ar_hs, r_hs, hs_any, busy, expire;

  assign aw_hs  = awvalid_q & m00_axi.awready;
  assign w_hs   = wvalid_q & m00_axi.wready;
  assign b_hs   = bready_q & m00_axi.bvalid;
  assign ar_hs  = arvalid_q & m00_axi.arready;
  assign r_hs   = rready_q & m00_axi.rvalid;
  assign hs_any = aw_hs | w_hs | b_hs | ar_hs | r_hs;
  assign busy   = (state_q != IDLE) && (state_q != RESP);

`ifdef AXIL_MASTER_TIMEOUT_EN
  axil_master_watchdog #(.LIMIT(TIMEOUT_CYCLES)) u_watchdog (
    .clk_i    (m00_axi_aclk),
    .rst_i    (m00_axi_areset),
    .run_i    (busy),
    .clear_i  (hs_any),
    .expire_o (expire)
  );
`else
  logic unused_cfg;
  assign expire     = 1'b0;
  assign unused_cfg = ^{busy, hs_any, 32'(TIMEOUT_CYCLES)};
`endif

  always_comb begin
    state_d     = state_q;
    cmd_ready_d = cmd_ready_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    bready_d    = bready_q;
    arvalid_d   = arvalid_q;
    rready_d    = rready_q;
    rsp_valid_d = rsp_valid_q;
    timeout_d   = timeout_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    rdata_d     = rdata_q;
    resp_d      = resp_q;
    if (expire) begin
      // Abandon the hung slave: drop every valid/ready and report SLVERR
      awvalid_d   = 1'b0;
      wvalid_d    = 1'b0;
      bready_d    = 1'b0;
      arvalid_d   = 1'b0;
      rready_d    = 1'b0;
      rsp_valid_d = 1'b1;
      timeout_d   = 1'b1;
      resp_d      = RESP_SLVERR;
      rdata_d     = '0;
      state_d     = RESP;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_d = 1'b0;
            addr_d      = cmd_addr;
            wdata_d     = cmd_wdata;
            wstrb_d     = cmd_wstrb;
            if (cmd_write) begin
              awvalid_d = 1'b1;
              wvalid_d  = 1'b1;
              state_d   = WR_ADDR_DATA;
            end else begin
              arvalid_d = 1'b1;
              state_d   = RD_ADDR;
            end
          end
        end
        WR_ADDR_DATA: begin
          if (aw_hs) awvalid_d = 1'b0;
          if (w_hs)  wvalid_d  = 1'b0;
          if ((aw_hs || !awvalid_q) && (w_hs || !wvalid_q)) begin
            bready_d = 1'b1;
            state_d  = WR_RESP;
          end
        end
        WR_RESP: begin
          if (b_hs) begin
            bready_d    = 1'b0;
            resp_d      = m00_axi.bresp;
            rdata_d     = '0;
            timeout_d   = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end
        end
        RD_ADDR: begin
          if (ar_hs) begin
            arvalid_d = 1'b0;
            rready_d  = 1'b1;
            state_d   = RD_DATA;
          end
        end
        RD_DATA: begin
          if (r_hs) begin
            rready_d    = 1'b0;
            resp_d      = m00_axi.rresp;
            rdata_d     = m00_axi.rdata;
            timeout_d   = 1'b0;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_d = 1'b0;
            cmd_ready_d = 1'b1;
            state_d     = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge m00_axi_aclk or posedge m00_axi_areset) begin
    if (m00_axi_areset) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b1;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      rdata_q     <= '0;
      resp_q      <= '0;
    end else begin
      state_q     <= state_d;
      cmd_ready_q <= cmd_ready_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      bready_q    <= bready_d;
      arvalid_q   <= arvalid_d;
      rready_q    <= rready_d;
      rsp_valid_q <= rsp_valid_d;
      timeout_q   <= timeout_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      rdata_q     <= rdata_d;
      resp_q      <= resp_d;
    end
  end

  assign cmd_ready       = cmd_ready_q;
  assign rsp_valid       = rsp_valid_q;
  assign rsp_rdata       = rdata_q;
  assign rsp_resp        = resp_q;
  assign rsp_timeout     = timeout_q;
  assign m00_axi.awaddr  = addr_q;
  assign m00_axi.awprot  = 3'b000;
  assign m00_axi.awvalid = awvalid_q;
  assign m00_axi.wdata   = wdata_q;
  assign m00_axi.wstrb   = wstrb_q;
  assign m00_axi.wvalid  = wvalid_q;
  assign m00_axi.bready  = bready_q;
  assign m00_axi.araddr  = addr_q;
  assign m00_axi.arprot  = 3'b000;
  assign m00_axi.arvalid = arvalid_q;
  assign m00_axi.rready  = rready_q;
endmodule

// File: doc/axil_master_engine.md
Name: axil_master_engine

Overview:
- AXI4-Lite initiator that converts a simple single-beat command stream into AXI4-Lite master transactions.
- It lets an on-chip sequencer program and poll the matrix-multiply accelerator slave in hardware:
  - dimension registers 0x08/0x0C/0x10,
  - control 0x00, status 0x04,
  - address 0x14, write data 0x18, read data 0x1C.
- It sits between the sequencer and the accelerator's s00_axi port. One outstanding transaction at a time.

Parameters:
- C_M00_AXI_ADDR_WIDTH, 8, AXI address width.
- C_M00_AXI_DATA_WIDTH, 32, AXI data width (strobe width = DATA/8).
- TIMEOUT_CYCLES, 1024, watchdog limit; used only with the optional feature.

Ports:
- m00_axi_aclk  in  1  single clock.
- m00_axi_areset  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  engine idle, can accept a command.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR  byte address.
- cmd_wdata  in  DATA  write data.
- cmd_wstrb  in  DATA/8  write strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA  read data; 0 for writes.
- rsp_resp  out  2  AXI response code (BRESP/RRESP, or timeout code).
- rsp_timeout  out  1  transaction aborted by watchdog; tied 0 when the feature is out.
- m00_axi_awaddr/awprot/awvalid  out  ADDR/3/1  write-address channel; awprot = 0.
- m00_axi_awready  in  1  write-address channel ready.
- m00_axi_wdata/wstrb/wvalid  out  DATA/DATA/8/1  write-data channel.
- m00_axi_wready  in  1  write-data channel ready.
- m00_axi_bresp  in  2  write response code.
- m00_axi_bvalid  in  1  write response valid.
- m00_axi_bready  out  1  write response ready.
- m00_axi_araddr/arprot/arvalid  out  ADDR/3/1  read-address channel; arprot = 0.
- m00_axi_arready  in  1  read-address channel ready.
- m00_axi_rdata  in  DATA  read data.
- m00_axi_rresp  in  2  read response code.
- m00_axi_rvalid  in  1  read data valid.
- m00_axi_rready  out  1  read data ready.

Behaviour:
- Reset values:
  - All valid/ready outputs 0, except cmd_ready = 1.
  - All address/data/resp outputs 0; state IDLE.
  - Reset asserted mid-transaction drops every valid immediately (asynchronous) and returns to IDLE. Any pending response is discarded.
- All outputs are registered.
- FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid at edge N: latch addr/wdata/wstrb and clear cmd_ready.
  - Write → WR_ADDR_DATA; awvalid and wvalid both high from N+1.
  - Read → RD_ADDR; arvalid high from N+1.
- WR_ADDR_DATA:
  - awvalid and wvalid are tracked independently.
  - Each is cleared on the edge where its own ready is sampled high; payload is held stable while valid.
  - Both handshakes may complete on the same edge or on different edges, in either order.
  - When both are done → WR_RESP with bready = 1.
- WR_RESP:
  - On bvalid & bready: capture bresp, drop bready → RESP.
  - bvalid arriving before both address/data handshakes complete is not acknowledged; bready stays 0.
- RD_ADDR: on arready, drop arvalid, raise rready → RD_DATA.
- RD_DATA: on rvalid & rready, capture rdata/rresp, drop rready → RESP.
- RESP:
  - rsp_valid = 1; rsp_rdata/rsp_resp held stable until rsp_ready.
  - On rsp_ready → IDLE with cmd_ready = 1 on the next cycle.
  - No command is accepted while a response is pending.
- rsp_resp passes SLVERR/DECERR unmodified; the engine never retries.
- Latency with a zero-wait slave:
  - Write: accept at N, AW/W handshake at N+1, B handshake at N+2, rsp_valid from N+3.
  - Read: accept at N, AR handshake at N+1, R handshake at N+2, rsp_valid from N+3.
- bvalid/rvalid seen outside their wait states are ignored, since the corresponding ready is 0.

Optional Feature:
- Macro AXIL_MASTER_TIMEOUT_EN.
- With the macro defined:
  - A counter runs in any non-IDLE, non-RESP state and clears on every channel handshake.
  - When the counter reaches TIMEOUT_CYCLES, all valids/readies drop → RESP with rsp_timeout = 1, rsp_resp = 2'b10, rsp_rdata = 0.
  - This is a debug recovery for a hung slave only; it breaks AXI handshake rules.
- Without the macro: no counter, rsp_timeout tied 0, and the engine waits indefinitely.

Decomposition:
- Package axil_master_pkg: FSM state encoding; response constants RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11; accelerator register offsets (CTRL 0x00, STATUS 0x04, DIM_M 0x08, DIM_K 0x0C, DIM_N 0x10, ADDR 0x14, WDATA 0x18, RDATA 0x1C).
- Sub-module axil_master_watchdog: counter, clear, expire output. Instantiated only under AXIL_MASTER_TIMEOUT_EN.

Test Plan:
- Write 0x08 ← 4 to a zero-wait slave:
  - awvalid = wvalid = 1 exactly one cycle.
  - rsp_valid 3 cycles after accept; rsp_resp = 00; rsp_rdata = 0.
- Slave awready delayed 3 cycles, wready immediate:
  - wvalid drops after 1 cycle, awvalid held 3 cycles with stable awaddr 0x14.
  - bready rises only after both handshakes.
- Write 0x0C ← 7, then read 0x0C:
  - rsp_rdata = 7; araddr stable while arvalid = 1.
  - rsp held through 5 cycles of rsp_ready = 0; cmd_ready stays 0 until released.
- Slave returns bresp = 10 → rsp_resp = 10 and no retry. Early bvalid while awready is still low → bready stays 0.
- Assert m00_axi_areset during WR_RESP → all valids/readies 0 in the same cycle, cmd_ready = 1 after release, and the next read succeeds.
- With AXIL_MASTER_TIMEOUT_EN and a slave that never asserts arready: rsp_timeout = 1, rsp_resp = 10, after TIMEOUT_CYCLES = 16 (bench override).
